// File: rtl/car_motion_ctrl_if.sv
// Request-processor <-> car motion controller signal bundle.
// The master side (request processor / door timer) drives the needs, the
// request mask and endOpen; the slave side (motion controller) returns the
// car position, direction and door/motion status.
interface car_motion_ctrl_if;
  logic       up_need;
  logic       down_need;
  logic [3:0] allReq_reg;
  logic       endOpen;
  logic [3:0] position;
  logic [1:0] floor_num;
  logic [1:0] ud_mode;
  logic       StOpen;
  logic       moving;

  modport master (
    output up_need, down_need, allReq_reg, endOpen,
    input  position, floor_num, ud_mode, StOpen, moving
  );

  modport slave (
    input  up_need, down_need, allReq_reg, endOpen,
    output position, floor_num, ud_mode, StOpen, moving
  );
endinterface

// File: rtl/car_motion_ctrl.sv
// Car motion controller: moves the car one floor at a time in the direction
// requested by the request processor, stops at requested floors or at the end
// of travel, runs a door cycle, then resumes, reverses or goes idle.
// All outputs are registered (Moore style).
module car_motion_ctrl #(
  parameter int FLOOR_TICKS = 8
) (
  input logic            clk,
  input logic            rst_n,
  car_motion_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MOVE     = 3'd1,
    ARRIVE   = 3'd2,
    DOOR     = 3'd3,
    DOOR_END = 3'd4
  } state_t;

  localparam logic [1:0] UD_STOP = 2'b00;
  localparam logic [1:0] UD_UP   = 2'b01;
  localparam logic [1:0] UD_DOWN = 2'b10;

  localparam logic [6:0] CNT_LAST = 7'(FLOOR_TICKS - 1);

  state_t     state_q, state_d;
  logic [3:0] pos_q, pos_d;
  logic [1:0] floor_q, floor_d;
  logic [1:0] ud_q, ud_d;
  logic       stopen_q, stopen_d;
  logic       moving_q, moving_d;
  logic [6:0] cnt_q, cnt_d;

  // Direction-relative view of the needs and shaft ends.
  logic going_up;
  logic dir_need;
  logic opp_need;
  logic dir_end;
  logic opp_end;

  assign going_up = (ud_q == UD_UP);
  assign dir_need = going_up ? bus.up_need : bus.down_need;
  assign opp_need = going_up ? bus.down_need : bus.up_need;
  assign dir_end  = going_up ? pos_q[3] : pos_q[0];
  assign opp_end  = going_up ? pos_q[0] : pos_q[3];

  // Next-state and next-output logic for the motion FSM.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    floor_d = floor_q;
    ud_d    = ud_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        ud_d = UD_STOP;
        if (bus.up_need && !pos_q[3]) begin
          state_d = MOVE;
          ud_d    = UD_UP;
          cnt_d   = '0;
        end else if (bus.down_need && !pos_q[0]) begin
          state_d = MOVE;
          ud_d    = UD_DOWN;
          cnt_d   = '0;
        end
      end

      MOVE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ARRIVE;
          // Shift guards keep the position one-hot even if ud_q were stale.
          if (going_up && !pos_q[3]) begin
            pos_d   = pos_q << 1;
            floor_d = floor_q + 2'd1;
          end else if (!going_up && !pos_q[0]) begin
            pos_d   = pos_q >> 1;
            floor_d = floor_q - 2'd1;
          end
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end

      ARRIVE: begin
        if (((bus.allReq_reg & pos_q) != 4'b0000) || dir_end || !dir_need) begin
          state_d = DOOR;
        end else begin
          state_d = MOVE;
          cnt_d   = '0;
        end
      end

      DOOR: begin
        if (bus.endOpen) begin
          state_d = DOOR_END;
        end
      end

      DOOR_END: begin
        if (dir_need && !dir_end) begin
          state_d = MOVE;
          cnt_d   = '0;
        end else if (opp_need && !opp_end) begin
          state_d = MOVE;
          ud_d    = going_up ? UD_DOWN : UD_UP;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          ud_d    = UD_STOP;
        end
      end

      default: begin
        state_d = IDLE;
        ud_d    = UD_STOP;
        cnt_d   = '0;
      end
    endcase

    // Door request and motion flag follow the state being entered.
    stopen_d = (state_d == DOOR);
    moving_d = (state_d == MOVE);
  end

  // State and registered-output update with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pos_q    <= 4'b0001;
      floor_q  <= 2'd0;
      ud_q     <= UD_STOP;
      stopen_q <= 1'b0;
      moving_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      floor_q  <= floor_d;
      ud_q     <= ud_d;
      stopen_q <= stopen_d;
      moving_q <= moving_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.position  = pos_q;
  assign bus.floor_num = floor_q;
  assign bus.ud_mode   = ud_q;
  assign bus.StOpen    = stopen_q;
  assign bus.moving    = moving_q;

endmodule

// File: tb/tb_car_motion_ctrl.sv
// Directed bench for the car motion controller: travel, stop, door handshake,
// end-of-shaft handling, reversal, up priority and asynchronous reset.
module tb_car_motion_ctrl;

  logic clk;
  logic rst_n;
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  car_motion_ctrl_if bus ();

  car_motion_ctrl #(.FLOOR_TICKS(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.up_need = 1'b0; bus.down_need = 1'b0;
    bus.allReq_reg = 4'b0000; bus.endOpen = 1'b0;
    #1;
    tick(2);
    total_cnt++; if (bus.position !== 4'b0001) $display("FAIL reset_position: got %b want 0001", bus.position); else pass_cnt++;
    total_cnt++; if (bus.floor_num !== 2'd0) $display("FAIL reset_floor: got %0d want 0", bus.floor_num); else pass_cnt++;
    total_cnt++; if (bus.ud_mode !== 2'b00) $display("FAIL reset_ud: got %b want 00", bus.ud_mode); else pass_cnt++;
    total_cnt++; if (bus.StOpen !== 1'b0) $display("FAIL reset_stopen: got %b want 0", bus.StOpen); else pass_cnt++;
    total_cnt++; if (bus.moving !== 1'b0) $display("FAIL reset_moving: got %b want 0", bus.moving); else pass_cnt++;
    rst_n = 1'b1;
    tick(1);
    total_cnt++; if (bus.moving !== 1'b0 || bus.ud_mode !== 2'b00) $display("FAIL idle_after_release: moving=%b ud=%b want 0/00", bus.moving, bus.ud_mode); else pass_cnt++;
    $display("test_reset done: position=%b ud=%b", bus.position, bus.ud_mode);
  endtask

  task automatic test_up_travel;
    bus.up_need = 1'b1; bus.allReq_reg = 4'b0100;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b01 || bus.moving !== 1'b1) $display("FAIL start_up: ud=%b moving=%b want 01/1", bus.ud_mode, bus.moving); else pass_cnt++;
    tick(7);
    total_cnt++; if (bus.position !== 4'b0001) $display("FAIL no_early_step: got %b want 0001", bus.position); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.position !== 4'b0010 || bus.floor_num !== 2'd1 || bus.moving !== 1'b0) $display("FAIL arrive_f2: pos=%b floor=%0d moving=%b want 0010/1/0", bus.position, bus.floor_num, bus.moving); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.moving !== 1'b1 || bus.StOpen !== 1'b0) $display("FAIL pass_f2: moving=%b stopen=%b want 1/0", bus.moving, bus.StOpen); else pass_cnt++;
    tick(8);
    total_cnt++; if (bus.position !== 4'b0100 || bus.floor_num !== 2'd2) $display("FAIL arrive_f3: pos=%b floor=%0d want 0100/2", bus.position, bus.floor_num); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.StOpen !== 1'b1 || bus.moving !== 1'b0 || bus.ud_mode !== 2'b01) $display("FAIL door_f3: stopen=%b moving=%b ud=%b want 1/0/01", bus.StOpen, bus.moving, bus.ud_mode); else pass_cnt++;
    $display("test_up_travel done: position=%b StOpen=%b", bus.position, bus.StOpen);
  endtask

  task automatic test_door_release;
    tick(3);
    total_cnt++; if (bus.StOpen !== 1'b1) $display("FAIL door_hold: stopen=%b want 1", bus.StOpen); else pass_cnt++;
    bus.up_need = 1'b0; bus.allReq_reg = 4'b0000; bus.endOpen = 1'b1;
    tick(1);
    bus.endOpen = 1'b0;
    total_cnt++; if (bus.StOpen !== 1'b0 || bus.ud_mode !== 2'b01) $display("FAIL door_end: stopen=%b ud=%b want 0/01", bus.StOpen, bus.ud_mode); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b00 || bus.StOpen !== 1'b0 || bus.moving !== 1'b0) $display("FAIL to_idle: ud=%b stopen=%b moving=%b want 00/0/0", bus.ud_mode, bus.StOpen, bus.moving); else pass_cnt++;
    bus.endOpen = 1'b1;
    tick(2);
    bus.endOpen = 1'b0;
    total_cnt++; if (bus.StOpen !== 1'b0 || bus.ud_mode !== 2'b00 || bus.position !== 4'b0100) $display("FAIL endopen_ignored: stopen=%b ud=%b pos=%b want 0/00/0100", bus.StOpen, bus.ud_mode, bus.position); else pass_cnt++;
    $display("test_door_release done: ud=%b StOpen=%b", bus.ud_mode, bus.StOpen);
  endtask

  task automatic test_top_end;
    bus.up_need = 1'b1; bus.allReq_reg = 4'b1000;
    tick(9);
    total_cnt++; if (bus.position !== 4'b1000 || bus.floor_num !== 2'd3) $display("FAIL arrive_f4: pos=%b floor=%0d want 1000/3", bus.position, bus.floor_num); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.StOpen !== 1'b1) $display("FAIL door_f4: stopen=%b want 1", bus.StOpen); else pass_cnt++;
    bus.endOpen = 1'b1;
    tick(1);
    bus.endOpen = 1'b0;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b00) $display("FAIL idle_f4: ud=%b want 00", bus.ud_mode); else pass_cnt++;
    tick(3);
    total_cnt++; if (bus.ud_mode !== 2'b00 || bus.position !== 4'b1000 || bus.moving !== 1'b0) $display("FAIL top_need_ignored: ud=%b pos=%b moving=%b want 00/1000/0", bus.ud_mode, bus.position, bus.moving); else pass_cnt++;
    bus.up_need = 1'b0;
    $display("test_top_end done: position=%b ud=%b", bus.position, bus.ud_mode);
  endtask

  task automatic test_reversal;
    bus.down_need = 1'b1; bus.allReq_reg = 4'b0010;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b10) $display("FAIL start_down: ud=%b want 10", bus.ud_mode); else pass_cnt++;
    tick(17);
    total_cnt++; if (bus.position !== 4'b0010 || bus.floor_num !== 2'd1) $display("FAIL arrive_f2_down: pos=%b floor=%0d want 0010/1", bus.position, bus.floor_num); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.StOpen !== 1'b1) $display("FAIL door_f2: stopen=%b want 1", bus.StOpen); else pass_cnt++;
    bus.down_need = 1'b0; bus.up_need = 1'b1; bus.allReq_reg = 4'b0000; bus.endOpen = 1'b1;
    tick(1);
    bus.endOpen = 1'b0;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b01 || bus.moving !== 1'b1) $display("FAIL reverse_up: ud=%b moving=%b want 01/1", bus.ud_mode, bus.moving); else pass_cnt++;
    tick(3);
    bus.up_need = 1'b0; bus.down_need = 1'b1;
    tick(6);
    total_cnt++; if (bus.position !== 4'b0100) $display("FAIL midmove_change: pos=%b want 0100", bus.position); else pass_cnt++;
    tick(1);
    total_cnt++; if (bus.StOpen !== 1'b1 || bus.ud_mode !== 2'b01) $display("FAIL stop_f3: stopen=%b ud=%b want 1/01", bus.StOpen, bus.ud_mode); else pass_cnt++;
    bus.endOpen = 1'b1;
    tick(1);
    bus.endOpen = 1'b0;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b10 || bus.moving !== 1'b1) $display("FAIL reverse_down: ud=%b moving=%b want 10/1", bus.ud_mode, bus.moving); else pass_cnt++;
    tick(7);
    total_cnt++; if (bus.position !== 4'b0100) $display("FAIL down_not_yet: pos=%b want 0100", bus.position); else pass_cnt++;
    tick(1);
    bus.down_need = 1'b0;
    total_cnt++; if (bus.position !== 4'b0010) $display("FAIL reach_f2: pos=%b want 0010", bus.position); else pass_cnt++;
    $display("test_reversal done: position=%b ud=%b", bus.position, bus.ud_mode);
  endtask

  task automatic test_up_priority;
    tick(1);
    bus.endOpen = 1'b1;
    tick(1);
    bus.endOpen = 1'b0;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b00 || bus.position !== 4'b0010) $display("FAIL idle_f2: ud=%b pos=%b want 00/0010", bus.ud_mode, bus.position); else pass_cnt++;
    bus.up_need = 1'b1; bus.down_need = 1'b1;
    tick(1);
    total_cnt++; if (bus.ud_mode !== 2'b01) $display("FAIL up_priority: ud=%b want 01", bus.ud_mode); else pass_cnt++;
    bus.down_need = 1'b0;
    $display("test_up_priority done: ud=%b", bus.ud_mode);
  endtask

  task automatic test_async_reset;
    tick(8);
    total_cnt++; if (bus.position !== 4'b0100) $display("FAIL pre_reset_f3: pos=%b want 0100", bus.position); else pass_cnt++;
    tick(6);
    total_cnt++; if (bus.moving !== 1'b1) $display("FAIL pre_reset_moving: moving=%b want 1", bus.moving); else pass_cnt++;
    rst_n = 1'b0;
    #2;
    total_cnt++; if (bus.position !== 4'b0001) $display("FAIL async_position: got %b want 0001", bus.position); else pass_cnt++;
    total_cnt++; if (bus.floor_num !== 2'd0) $display("FAIL async_floor: got %0d want 0", bus.floor_num); else pass_cnt++;
    total_cnt++; if (bus.ud_mode !== 2'b00) $display("FAIL async_ud: got %b want 00", bus.ud_mode); else pass_cnt++;
    total_cnt++; if (bus.StOpen !== 1'b0 || bus.moving !== 1'b0) $display("FAIL async_flags: stopen=%b moving=%b want 0/0", bus.StOpen, bus.moving); else pass_cnt++;
    tick(1);
    bus.up_need = 1'b0; bus.down_need = 1'b1;
    rst_n = 1'b1;
    tick(3);
    total_cnt++; if (bus.ud_mode !== 2'b00 || bus.position !== 4'b0001 || bus.moving !== 1'b0) $display("FAIL bottom_need_ignored: ud=%b pos=%b moving=%b want 00/0001/0", bus.ud_mode, bus.position, bus.moving); else pass_cnt++;
    bus.down_need = 1'b0;
    $display("test_async_reset done: position=%b ud=%b", bus.position, bus.ud_mode);
  endtask

  initial begin
    test_reset();
    test_up_travel();
    test_door_release();
    test_top_end();
    test_reversal();
    test_up_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
